// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one split-transaction memory port between instruction and data requesters
module mem_port_arbiter #(
   parameter int MAX_OUTSTANDING = 3,
   parameter bit FAIR            = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        i_req,
   output logic        i_gnt,
   input  logic [31:0] i_addr,
   output logic        i_recv,
   input  logic        i_ack,
   input  logic        d_req,
   output logic        d_gnt,
   input  logic [31:0] d_addr,
   input  logic        d_wen,
   input  logic [3:0]  d_strb,
   input  logic [31:0] d_wdata,
   output logic        d_recv,
   input  logic        d_ack,
   output logic [31:0] s_rdata,
   output logic        s_error,
   output logic        m_req,
   input  logic        m_gnt,
   output logic [31:0] m_addr,
   output logic        m_wen,
   output logic [3:0]  m_strb,
   output logic [31:0] m_wdata,
   input  logic        m_recv,
   output logic        m_ack,
   input  logic [31:0] m_rdata,
   input  logic        m_error
);
   localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [PW-1:0] LAST = PW'(MAX_OUTSTANDING - 1);
   localparam logic [CW-1:0] FULL = CW'(MAX_OUTSTANDING);

   logic [MAX_OUTSTANDING-1:0] tags;
   logic [PW-1:0]              wr_ptr, rd_ptr;
   logic [CW-1:0]              count;
   logic                       lock, lock_sel, rr_ptr;
   logic                       sel, sel_req, empty, head, push, pop;

   // sel/head/tags: 0 = instruction, 1 = data
   always_comb begin
      sel     = lock ? lock_sel : (i_req && d_req) ? (FAIR ? rr_ptr : 1'b1) : d_req;
      sel_req = sel ? d_req : i_req;
      m_req   = sel_req && (count < FULL);
      i_gnt   = m_gnt && m_req && !sel;
      d_gnt   = m_gnt && m_req && sel;
      m_addr  = sel ? d_addr : i_addr;
      m_wen   = sel && d_wen;
      m_strb  = sel ? d_strb : 4'hF;
      m_wdata = sel ? d_wdata : 32'h0;
      empty   = count == '0;
      head    = tags[rd_ptr];
      i_recv  = !empty && !head && m_recv;
      d_recv  = !empty && head && m_recv;
      m_ack   = !empty && (head ? d_ack : i_ack);
      s_rdata = m_rdata;
      s_error = m_error;
      push    = m_gnt && m_req;
      pop     = m_recv && m_ack;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         tags     <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         lock     <= 1'b0;
         lock_sel <= 1'b0;
         rr_ptr   <= 1'b0;
      end else begin
         lock     <= m_req && !m_gnt;
         lock_sel <= sel;
         if (push) begin
            tags[wr_ptr] <= sel;
            wr_ptr       <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
            rr_ptr       <= !sel;
         end
         if (pop)
            rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, locking, FIFO limits, ordering and reset
module tb_mem_port_arbiter;
   logic        clock = 0, reset = 0;
   logic        i_req = 0, i_ack = 0, d_req = 0, d_ack = 0, d_wen = 0;
   logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, m_rdata = 0;
   logic [3:0]  d_strb = 0;
   logic        m_gnt = 0, m_recv = 0, m_error = 0;
   logic        i_gnt, i_recv, d_gnt, d_recv, s_error, m_req, m_wen, m_ack;
   logic [31:0] s_rdata, m_addr, m_wdata;
   logic [3:0]  m_strb;
   int          n_cmp = 0, n_err = 0;

   mem_port_arbiter #(.MAX_OUTSTANDING(3), .FAIR(1)) dut (
      .clock(clock), .reset(reset),
      .i_req(i_req), .i_gnt(i_gnt), .i_addr(i_addr), .i_recv(i_recv), .i_ack(i_ack),
      .d_req(d_req), .d_gnt(d_gnt), .d_addr(d_addr), .d_wen(d_wen), .d_strb(d_strb),
      .d_wdata(d_wdata), .d_recv(d_recv), .d_ack(d_ack),
      .s_rdata(s_rdata), .s_error(s_error),
      .m_req(m_req), .m_gnt(m_gnt), .m_addr(m_addr), .m_wen(m_wen), .m_strb(m_strb),
      .m_wdata(m_wdata), .m_recv(m_recv), .m_ack(m_ack), .m_rdata(m_rdata), .m_error(m_error)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1;
      tick();
      reset = 0;
      #1;
      chk("rst_m_req", m_req, 0);
      chk("rst_i_gnt", i_gnt, 0);
      chk("rst_d_gnt", d_gnt, 0);
      chk("rst_i_recv", i_recv, 0);
      chk("rst_d_recv", d_recv, 0);
      chk("rst_m_ack", m_ack, 0);

      // single instruction fetch
      i_req = 1; i_addr = 32'h100; m_gnt = 1;
      #1;
      chk("if_m_req", m_req, 1);
      chk("if_i_gnt", i_gnt, 1);
      chk("if_d_gnt", d_gnt, 0);
      chk("if_m_addr", m_addr, 32'h100);
      chk("if_m_strb", m_strb, 4'hF);
      chk("if_m_wen", m_wen, 0);
      chk("if_m_wdata", m_wdata, 0);
      tick();
      i_req = 0; m_gnt = 0; m_recv = 1; i_ack = 1; m_rdata = 32'h1234;
      #1;
      chk("if_i_recv", i_recv, 1);
      chk("if_d_recv", d_recv, 0);
      chk("if_m_ack", m_ack, 1);
      chk("if_s_rdata", s_rdata, 32'h1234);
      tick();
      #1;
      chk("if_empty_i_recv", i_recv, 0);
      chk("if_empty_m_ack", m_ack, 0);

      // round-robin contention with a response drained every cycle
      reset = 1; m_recv = 0;
      tick();
      reset = 0;
      i_req = 1; d_req = 1; i_addr = 32'h200; d_addr = 32'h300; m_gnt = 1;
      m_recv = 1; i_ack = 1; d_ack = 1;
      #1;
      chk("rr0_i_gnt", i_gnt, 1);
      chk("rr0_d_gnt", d_gnt, 0);
      chk("rr0_m_ack", m_ack, 0);
      tick(); #1;
      chk("rr1_d_gnt", d_gnt, 1);
      chk("rr1_i_gnt", i_gnt, 0);
      chk("rr1_m_addr", m_addr, 32'h300);
      chk("rr1_i_recv", i_recv, 1);
      tick(); #1;
      chk("rr2_i_gnt", i_gnt, 1);
      chk("rr2_d_recv", d_recv, 1);
      tick(); #1;
      chk("rr3_d_gnt", d_gnt, 1);
      chk("rr3_i_recv", i_recv, 1);
      tick();
      i_req = 0; d_req = 0;
      #1;
      chk("rr4_d_recv", d_recv, 1);
      tick(); #1;
      chk("rr5_empty_m_ack", m_ack, 0);

      // stall lock: data selected and held while instruction arrives
      m_recv = 0; m_gnt = 0;
      d_req = 1; d_addr = 32'hD0; d_wen = 1; d_strb = 4'h3; d_wdata = 32'h55;
      #1;
      chk("lk0_m_addr", m_addr, 32'hD0);
      chk("lk0_m_wen", m_wen, 1);
      chk("lk0_m_wdata", m_wdata, 32'h55);
      chk("lk0_d_gnt", d_gnt, 0);
      tick();
      i_req = 1; i_addr = 32'h10;
      #1;
      chk("lk1_m_addr", m_addr, 32'hD0);
      chk("lk1_m_strb", m_strb, 4'h3);
      tick(); #1;
      chk("lk2_m_addr", m_addr, 32'hD0);
      tick();
      m_gnt = 1;
      #1;
      chk("lk3_d_gnt", d_gnt, 1);
      chk("lk3_i_gnt", i_gnt, 0);
      chk("lk3_m_addr", m_addr, 32'hD0);
      tick();
      d_req = 0;
      #1;
      chk("lk4_i_gnt", i_gnt, 1);
      chk("lk4_m_addr", m_addr, 32'h10);
      chk("lk4_m_wen", m_wen, 0);
      tick();

      // full FIFO: outstanding d, i; third grant then blocked
      i_req = 0; d_req = 1; d_addr = 32'hE0;
      #1;
      chk("fl0_d_gnt", d_gnt, 1);
      tick(); #1;
      chk("fl1_m_req", m_req, 0);
      chk("fl1_d_gnt", d_gnt, 0);
      m_recv = 1; d_ack = 1; i_ack = 0; m_rdata = 32'hAAAA;
      #1;
      chk("fl2_d_recv", d_recv, 1);
      chk("fl2_m_req_pop", m_req, 0);
      chk("fl2_d_gnt_pop", d_gnt, 0);
      tick();
      m_recv = 0;
      #1;
      chk("fl3_m_req", m_req, 1);
      chk("fl3_d_gnt", d_gnt, 1);
      tick();

      // in-order responses: head i then d
      d_req = 0; m_gnt = 0; m_recv = 1; i_ack = 1; d_ack = 1; m_rdata = 32'hAAAA;
      #1;
      chk("or0_i_recv", i_recv, 1);
      chk("or0_d_recv", d_recv, 0);
      chk("or0_s_rdata", s_rdata, 32'hAAAA);
      tick();
      m_rdata = 32'hBBBB; m_error = 1;
      #1;
      chk("or1_d_recv", d_recv, 1);
      chk("or1_i_recv", i_recv, 0);
      chk("or1_s_rdata", s_rdata, 32'hBBBB);
      chk("or1_s_error", s_error, 1);
      tick();
      m_recv = 0; m_error = 0;

      // reset with outstanding requests drops all tags
      i_req = 1; m_gnt = 1;
      #1;
      chk("rs0_i_gnt", i_gnt, 1);
      tick();
      i_req = 0; m_gnt = 0; reset = 1;
      tick();
      reset = 0; m_recv = 1;
      #1;
      chk("rs1_i_recv", i_recv, 0);
      chk("rs1_d_recv", d_recv, 0);
      chk("rs1_m_ack", m_ack, 0);
      chk("rs1_m_req", m_req, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
